// File: rtl/uart_pkg.sv
// Shared UART definitions: serial FSM state types, status-word layout and the
// address window that the slot-3 decoder uses to route loads/stores here.
package uart_pkg;

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_t;
    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_t;

    // Status word: {16'b0, overrun, tx_full, rx_empty, 5'b0, rx_count[7:0]}
    localparam int unsigned STAT_OVERRUN_BIT  = 15;
    localparam int unsigned STAT_TX_FULL_BIT  = 14;
    localparam int unsigned STAT_RX_EMPTY_BIT = 13;
    localparam int unsigned STAT_COUNT_LSB    = 0;
    localparam int unsigned STAT_COUNT_W      = 8;

    // UART address window, shared with decode
    localparam logic [31:0] UART_BASE = 32'hFFFF_FF00;
    localparam logic [31:0] UART_MASK = 32'hFFFF_FFF8;

    function automatic logic [31:0] status_word(input logic       overrun,
                                                input logic       tx_full,
                                                input logic       rx_empty,
                                                input logic [7:0] count);
        logic [31:0] w;
        w = '0;
        w[STAT_OVERRUN_BIT]                   = overrun;
        w[STAT_TX_FULL_BIT]                   = tx_full;
        w[STAT_RX_EMPTY_BIT]                  = rx_empty;
        w[STAT_COUNT_LSB +: STAT_COUNT_W]     = count;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead output. Flags derive from the registered
// occupancy only; a push into an empty FIFO is visible on the next cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    // Qualify requests against the registered flags
    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CNT_FULL);
        push_ok = push && !full;
        pop_ok  = pop && !empty;
        dout    = mem[rd_ptr_q];
        count   = count_q;
    end

    // Storage array; no reset needed, occupancy guards reads
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (push_ok && !pop_ok)      count_q <= count_q + CNT_ONE;
            else if (pop_ok && !push_ok) count_q <= count_q - CNT_ONE;
        end
    end

endmodule

// File: rtl/uart_io.sv
// Memory-mapped UART endpoint on slot 3: RX deserializer, TX serializer and a
// FIFO per direction. Optional status register guarded by UART_STATUS_EN.
module uart_io
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic        txd,
    input  logic        stall_in,
    input  logic        io_re,
    input  logic        io_we,
    input  logic        io_sel,
    input  logic [7:0]  io_wdata,
    output logic [31:0] io_rdata,
    output logic        uart_stall
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    // Request decode
    logic rd_data, rd_stat, accept, rx_pop, tx_push, stat_acc;

    // FIFO interfaces
    logic        rx_push_q, rx_empty, rx_full;
    logic [7:0]  rx_dout;
    logic [AW:0] rx_count;
    logic        tx_pop, tx_empty, tx_full;
    logic [7:0]  tx_dout;
    logic [AW:0] unused_tx_count;

    // RX engine
    logic            rxd_meta_q, rxd_sync_q, rxd_prev_q;
    rx_state_t       rx_state_q;
    logic [CW-1:0]   rx_cnt_q;
    logic [2:0]      rx_bits_q;
    logic [7:0]      rx_shift_q;

    // TX engine
    tx_state_t       tx_state_q;
    logic [CW-1:0]   tx_cnt_q;
    logic [2:0]      tx_bits_q;
    logic [7:0]      tx_shift_q;
    logic            txd_q;

    logic [31:0]     rdata_q;
    logic [31:0]     stat_word;

    // Request decode and stall; a write always wins over a read
    always_comb begin
`ifdef UART_STATUS_EN
        rd_data = io_re && !io_we && !io_sel;
        rd_stat = io_re && !io_we && io_sel;
`else
        rd_data = io_re && !io_we;
        rd_stat = 1'b0;
`endif
        uart_stall = (rd_data && rx_empty) || (io_we && tx_full);
        accept     = !stall_in && !uart_stall;
        rx_pop     = accept && rd_data;
        tx_push    = accept && io_we;
        stat_acc   = accept && rd_stat;
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push_q),
        .pop   (rx_pop),
        .din   (rx_shift_q),
        .dout  (rx_dout),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count)
    );

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (io_wdata),
        .dout  (tx_dout),
        .empty (tx_empty),
        .full  (tx_full),
        .count (unused_tx_count)
    );

    // Two-flop synchronizer plus edge-detect history, idle-high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    // RX deserializer: mid-bit sampling, LSB first, one-cycle push pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bits_q  <= '0;
            rx_shift_q <= '0;
            rx_push_q  <= 1'b0;
        end else begin
            rx_push_q <= 1'b0;
            unique case (rx_state_q)
                RxIdle: begin
                    if (rxd_prev_q && !rxd_sync_q) begin
                        rx_state_q <= RxStart;
                        rx_cnt_q   <= '0;
                        rx_bits_q  <= '0;
                    end
                end
                RxStart: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= rxd_sync_q ? RxIdle : RxData;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                RxData: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rxd_sync_q, rx_shift_q[7:1]};
                        rx_bits_q  <= rx_bits_q + 3'd1;
                        if (rx_bits_q == 3'd7) rx_state_q <= RxStop;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                RxStop: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RxIdle;
                        // Framing error (stop bit low) drops the byte
                        if (rxd_sync_q) rx_push_q <= 1'b1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
            endcase
        end
    end

    // Load the next byte from idle, or straight out of the stop bit so
    // consecutive frames have no idle gap
    always_comb begin
        tx_pop = !tx_empty &&
                 ((tx_state_q == TxIdle) ||
                  ((tx_state_q == TxStop) && (tx_cnt_q == BIT_LAST)));
    end

    // TX serializer with registered txd
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bits_q  <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else if (tx_pop) begin
            tx_state_q <= TxStart;
            tx_cnt_q   <= '0;
            tx_shift_q <= tx_dout;
            txd_q      <= 1'b0;
        end else begin
            unique case (tx_state_q)
                TxIdle: begin
                    txd_q <= 1'b1;
                end
                TxStart: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_bits_q  <= '0;
                        tx_state_q <= TxData;
                        txd_q      <= tx_shift_q[0];
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_ONE;
                    end
                end
                TxData: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_bits_q == 3'd7) begin
                            tx_state_q <= TxStop;
                            txd_q      <= 1'b1;
                        end else begin
                            tx_bits_q  <= tx_bits_q + 3'd1;
                            txd_q      <= tx_shift_q[0];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_ONE;
                    end
                end
                TxStop: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_state_q <= TxIdle;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_ONE;
                    end
                end
            endcase
        end
    end

`ifdef UART_STATUS_EN
    logic overrun_q;

    // Sticky overrun: a completed byte arrived while RX was full; a status
    // read clears it, but a new overrun in the same cycle wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_q <= 1'b0;
        end else if (rx_push_q && rx_full) begin
            overrun_q <= 1'b1;
        end else if (stat_acc) begin
            overrun_q <= 1'b0;
        end
    end

    assign stat_word = status_word(overrun_q, tx_full, rx_empty, 8'(rx_count));
`else
    logic unused_status;
    assign unused_status = ^{io_sel, rx_count};
    assign stat_word     = '0;
`endif

    // Load result register; holds until the next accepted read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (rx_pop) begin
            rdata_q <= {24'b0, rx_dout};
        end else if (stat_acc) begin
            rdata_q <= stat_word;
        end
    end

    assign io_rdata = rdata_q;
    assign txd      = txd_q;

endmodule

// File: tb/tb_uart_io.sv
// Self-checking bench for uart_io with CLK_PER_BIT=8, FIFO_DEPTH=4.
module tb_uart_io;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rxd = 1'b1;
    logic        stall_in = 1'b0;
    logic        io_re = 1'b0;
    logic        io_we = 1'b0;
    logic        io_sel = 1'b0;
    logic [7:0]  io_wdata = 8'h00;
    logic        txd;
    logic [31:0] io_rdata;
    logic        uart_stall;

    int checks = 0;
    int errors = 0;

    logic [7:0]  rx_model[$];
    logic [7:0]  tx_bytes[$];
    logic [31:0] exp_rdata = 32'h0;

    always #5 clk = ~clk;

    uart_io #(
        .CLK_PER_BIT (CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .txd        (txd),
        .stall_in   (stall_in),
        .io_re      (io_re),
        .io_we      (io_we),
        .io_sel     (io_sel),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata),
        .uart_stall (uart_stall)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Serialize one frame onto rxd; caller is at a negedge
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    // One read request; returns the stall seen before the edge and io_rdata after
    task automatic do_read(input logic sel, output logic [31:0] val, output logic stalled);
        io_re  = 1'b1;
        io_sel = sel;
        #1;
        stalled = uart_stall;
        @(posedge clk);
        @(negedge clk);
        val    = io_rdata;
        io_re  = 1'b0;
        io_sel = 1'b0;
    endtask

    // Compare txd against the expected frames of tx_bytes, one check per bit time
    task automatic capture_tx(input string name);
        int waited = 0;
        logic [CPB-1:0] seen;
        logic [CPB-1:0] want;
        logic eb;
        while (txd !== 1'b0 && waited < 4 * CPB) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (txd !== 1'b0) begin
            errors++;
            $display("FAIL %s start: txd=%b required 0 within %0d cycles", name, txd, 4 * CPB);
            return;
        end
        for (int f = 0; f < tx_bytes.size(); f++) begin
            for (int k = 0; k < 10; k++) begin
                eb   = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : tx_bytes[f][k-1];
                want = {CPB{eb}};
                for (int c = 0; c < CPB; c++) begin
                    seen[c] = txd;
                    @(negedge clk);
                end
                checks++;
                if (seen !== want) begin
                    errors++;
                    $display("FAIL %s byte%0d bit%0d: txd=%b required %b", name, f, k, seen, want);
                end
            end
        end
    endtask

    task automatic test_reset;
        #22;
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b required 1", txd); end
        checks++;
        if (io_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h required 0", io_rdata);
        end
        checks++;
        if (uart_stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b required 0", uart_stall);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        io_re = 1'b1;
        #1;
        checks++;
        if (uart_stall !== 1'b1) begin
            errors++; $display("FAIL reset_rx_empty: stall=%b required 1", uart_stall);
        end
        io_re = 1'b0;
        io_we = 1'b1;
        #1;
        checks++;
        if (uart_stall !== 1'b0) begin
            errors++; $display("FAIL reset_tx_notfull: stall=%b required 0", uart_stall);
        end
        io_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_empty;
        io_re = 1'b1;
        #1;
        checks++;
        if (uart_stall !== 1'b1) begin
            errors++; $display("FAIL rd_empty_stall: got %b required 1", uart_stall);
        end
        fork
            send_frame(8'hA5, 1'b1);
            begin
                int n = 0;
                while (uart_stall === 1'b1 && n < 12 * CPB) begin
                    @(negedge clk);
                    #1;
                    n++;
                end
                checks++;
                if (uart_stall !== 1'b0) begin
                    errors++; $display("FAIL rd_empty_release: stall=%b required 0", uart_stall);
                end
                checks++;
                if (n < 9 * CPB || n > 11 * CPB) begin
                    errors++;
                    $display("FAIL rd_empty_latency: %0d cycles required %0d..%0d",
                             n, 9 * CPB, 11 * CPB);
                end
                checks++;
                if (io_rdata !== 32'h0) begin
                    errors++; $display("FAIL rd_empty_pre: got %h required 0", io_rdata);
                end
                @(posedge clk);
                @(negedge clk);
                checks++;
                if (io_rdata !== 32'h0000_00A5) begin
                    errors++; $display("FAIL rd_empty_data: got %h required 000000a5", io_rdata);
                end
                io_re = 1'b0;
            end
        join
        exp_rdata = 32'h0000_00A5;
        repeat (3) @(negedge clk);
        checks++;
        if (io_rdata !== exp_rdata) begin
            errors++; $display("FAIL rd_hold: got %h required %h", io_rdata, exp_rdata);
        end
    endtask

    task automatic test_rx_random;
        logic [7:0]  b;
        logic [31:0] val;
        logic        st;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            rx_model.push_back(b);
            send_frame(b, 1'b1);
        end
        repeat (2 * CPB) @(negedge clk);
        // External stall holds off acceptance even with data available
        stall_in = 1'b1;
        io_re    = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (uart_stall !== 1'b0) begin
            errors++; $display("FAIL stall_in_own: uart_stall=%b required 0", uart_stall);
        end
        checks++;
        if (io_rdata !== exp_rdata) begin
            errors++; $display("FAIL stall_in_hold: got %h required %h", io_rdata, exp_rdata);
        end
        @(negedge clk);
        io_re    = 1'b0;
        stall_in = 1'b0;
        while (rx_model.size() > 0) begin
            do_read(1'b0, val, st);
            exp_rdata = {24'b0, rx_model.pop_front()};
            checks++;
            if (st !== 1'b0) begin errors++; $display("FAIL rx_rand_stall: got %b required 0", st); end
            checks++;
            if (val !== exp_rdata) begin
                errors++; $display("FAIL rx_rand_data: got %h required %h", val, exp_rdata);
            end
        end
        io_re = 1'b1;
        #1;
        checks++;
        if (uart_stall !== 1'b1) begin
            errors++; $display("FAIL rx_rand_drained: stall=%b required 1", uart_stall);
        end
        io_re = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_tx_back_to_back;
        logic [2*CPB-1:0] tail;
        tx_bytes = {8'h55, 8'h0F};
        fork
            capture_tx("tx_b2b");
            begin
                io_we = 1'b1;
                io_wdata = 8'h55;
                #1;
                checks++;
                if (uart_stall !== 1'b0) begin
                    errors++; $display("FAIL tx_b2b_w0: stall=%b required 0", uart_stall);
                end
                @(negedge clk);
                io_wdata = 8'h0F;
                #1;
                checks++;
                if (uart_stall !== 1'b0) begin
                    errors++; $display("FAIL tx_b2b_w1: stall=%b required 0", uart_stall);
                end
                @(negedge clk);
                io_we = 1'b0;
            end
        join
        for (int c = 0; c < 2 * CPB; c++) begin
            tail[c] = txd;
            @(negedge clk);
        end
        checks++;
        if (tail !== {(2 * CPB){1'b1}}) begin
            errors++; $display("FAIL tx_b2b_idle: txd=%b required all 1", tail);
        end
    endtask

    task automatic test_tx_random;
        tx_bytes = {};
        for (int i = 0; i < 3; i++) tx_bytes.push_back(8'($urandom));
        fork
            capture_tx("tx_rand");
            begin
                for (int i = 0; i < 3; i++) begin
                    io_we = 1'b1;
                    io_wdata = tx_bytes[i];
                    @(negedge clk);
                end
                io_we = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tx_full;
        tx_bytes = {};
        for (int i = 0; i < 6; i++) tx_bytes.push_back(8'($urandom));
        fork
            capture_tx("tx_full");
            begin
                int n = 0;
                io_we = 1'b1;
                io_wdata = tx_bytes[0];
                @(negedge clk);
                io_we = 1'b0;
                repeat (3) @(negedge clk);
                for (int k = 1; k <= DEPTH; k++) begin
                    io_we = 1'b1;
                    io_wdata = tx_bytes[k];
                    #1;
                    checks++;
                    if (uart_stall !== 1'b0) begin
                        errors++; $display("FAIL tx_fill_%0d: stall=%b required 0", k, uart_stall);
                    end
                    @(negedge clk);
                end
                io_wdata = tx_bytes[DEPTH+1];
                #1;
                checks++;
                if (uart_stall !== 1'b1) begin
                    errors++; $display("FAIL tx_full_stall: stall=%b required 1", uart_stall);
                end
                while (uart_stall === 1'b1 && n < 12 * CPB) begin
                    @(negedge clk);
                    #1;
                    n++;
                end
                checks++;
                if (uart_stall !== 1'b0) begin
                    errors++; $display("FAIL tx_full_release: stall=%b required 0", uart_stall);
                end
                checks++;
                if (n < 6 * CPB || n > 11 * CPB) begin
                    errors++;
                    $display("FAIL tx_full_wait: %0d cycles required %0d..%0d",
                             n, 6 * CPB, 11 * CPB);
                end
                @(posedge clk);
                @(negedge clk);
                io_we = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
    endtask

    task automatic test_rx_noise;
        logic [7:0]  v;
        logic [31:0] val;
        logic        st;
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        io_re = 1'b1;
        #1;
        checks++;
        if (uart_stall !== 1'b1) begin
            errors++; $display("FAIL rx_glitch: stall=%b required 1 (nothing pushed)", uart_stall);
        end
        io_re = 1'b0;
        @(negedge clk);
        send_frame(8'hC3, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        io_re = 1'b1;
        #1;
        checks++;
        if (uart_stall !== 1'b1) begin
            errors++; $display("FAIL rx_framing: stall=%b required 1 (byte dropped)", uart_stall);
        end
        io_re = 1'b0;
        @(negedge clk);
        v = 8'($urandom) | 8'h01;
        send_frame(v, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        do_read(1'b0, val, st);
        exp_rdata = {24'b0, v};
        checks++;
        if (val !== exp_rdata || st !== 1'b0) begin
            errors++;
            $display("FAIL rx_after_noise: data=%h stall=%b required %h stall 0", val, st, exp_rdata);
        end
    endtask

`ifdef UART_STATUS_EN
    task automatic test_status;
        logic [7:0]  b;
        logic [31:0] val;
        logic [31:0] want;
        logic        st;
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            if (i < DEPTH) rx_model.push_back(b);
            send_frame(b, 1'b1);
        end
        repeat (2 * CPB) @(negedge clk);
        want = 32'h0;
        want[15] = 1'b1;
        want[7:0] = 8'(DEPTH);
        do_read(1'b1, val, st);
        checks++;
        if (st !== 1'b0 || val !== want) begin
            errors++; $display("FAIL status_overrun: got %h stall %b required %h", val, st, want);
        end
        want[15] = 1'b0;
        do_read(1'b1, val, st);
        checks++;
        if (val !== want) begin
            errors++; $display("FAIL status_clear: got %h required %h", val, want);
        end
        while (rx_model.size() > 0) begin
            do_read(1'b0, val, st);
            exp_rdata = {24'b0, rx_model.pop_front()};
            checks++;
            if (val !== exp_rdata) begin
                errors++; $display("FAIL status_drain: got %h required %h", val, exp_rdata);
            end
        end
        want = 32'h0;
        want[13] = 1'b1;
        do_read(1'b1, val, st);
        exp_rdata = want;
        checks++;
        if (val !== want) begin
            errors++; $display("FAIL status_empty: got %h required %h", val, want);
        end
    endtask
`endif

    task automatic test_reset_mid_frame;
        int bad = 0;
        io_we = 1'b1;
        io_wdata = 8'h00;
        @(negedge clk);
        @(negedge clk);
        io_we = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        checks++;
        if (txd !== 1'b0) begin
            errors++; $display("FAIL mid_frame_pre: txd=%b required 0", txd);
        end
        checks++;
        if (io_rdata !== exp_rdata) begin
            errors++; $display("FAIL mid_frame_rdata: got %h required %h", io_rdata, exp_rdata);
        end
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL rst_mid_txd: got %b required 1", txd); end
        checks++;
        if (io_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_mid_rdata: got %h required 0", io_rdata);
        end
        checks++;
        if (uart_stall !== 1'b0) begin
            errors++; $display("FAIL rst_mid_stall: got %b required 0", uart_stall);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        io_re = 1'b1;
        #1;
        checks++;
        if (uart_stall !== 1'b1) begin
            errors++; $display("FAIL rst_mid_rx_empty: stall=%b required 1", uart_stall);
        end
        io_re = 1'b0;
        repeat (12 * CPB) begin
            @(negedge clk);
            if (txd !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL rst_mid_tx_flushed: %0d low cycles required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_read_empty();
        test_rx_random();
        test_tx_back_to_back();
        test_tx_random();
        test_tx_full();
        test_rx_noise();
`ifdef UART_STATUS_EN
        test_status();
`endif
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
